// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle sequencing FSM for a MIPS-style datapath.
// It steps each instruction through FETCH / DECODE / EXEC / MEM / WB and drives
// the datapath write enables, mux selects and the ALU-op code. It also counts
// retired instructions.
//
// Ports:
//   CLK, RST          clock (rising edge) and asynchronous active-high reset
//   run               1 = execute; 0 = stop at the next instruction boundary
//   op, funct         instruction[31:26] / instruction[5:0] from the IR
//   zero              ALU zero flag (used live for beq in EXEC)
//   mem_ready         data memory completed the current access
//   pc_we, pc_src     PC load enable; 00 PC+4, 01 branch, 10 jump
//   ir_we             instruction register load
//   reg_we, reg_dst   register write enable; 1 = rd, 0 = rt
//   alu_src, alu_op   0 = reg B, 1 = immediate; 000 add, 001 sub, 010 funct
//   mem_re, mem_we    data memory read / write strobes
//   wb_sel            1 = ALU result, 0 = memory data
//   state, halted     current state code; 1 while in HALT
//   err               00 none, 01 illegal opcode, 10 memory timeout (sticky)
//   retired           retired-instruction counter
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        run,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        ir_we,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        mem_re,
  output logic        mem_we,
  output logic        wb_sel,
  output logic [2:0]  state,
  output logic        halted,
  output logic [1:0]  err,
  output logic [31:0] retired
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StMem    = 3'd4;
  localparam logic [2:0] StWb     = 3'd5;
  localparam logic [2:0] StHalt   = 3'd6;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam int unsigned   CntW     = $clog2(MEM_TIMEOUT + 1);
  // Counter value seen during the MEM_TIMEOUT-th MEM cycle.
  localparam logic [CntW-1:0] WaitLast = CntW'(MEM_TIMEOUT - 1);

  logic [2:0]      state_q, state_d;
  logic [5:0]      op_q;
  logic [5:0]      funct_q;
  logic [CntW-1:0] wait_q, wait_d;
  logic [1:0]      err_q, err_d;
  logic [31:0]     retired_q, retired_d;
  logic            op_legal;
  logic            retire;

  // The ALU control block decodes funct straight from the IR; the latched copy
  // is kept only so both instruction fields are frozen together.
  logic unused_funct;
  assign unused_funct = ^funct_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      op_q      <= 6'd0;
      funct_q   <= 6'd0;
      wait_q    <= '0;
      err_q     <= 2'b00;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      retired_q <= retired_d;
      if (state_q == StDecode) begin
        op_q    <= op;
        funct_q <= funct;
      end
    end
  end

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OpRtype, OpAddi, OpLw, OpSw, OpBeq, OpJ: op_legal = 1'b1;
      default:                                 op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    err_d     = err_q;
    retired_d = retired_q;
    retire    = 1'b0;
    case (state_q)
      StIdle:   if (run) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        if (op_legal) begin
          state_d = StExec;
        end else begin
          state_d = StHalt;
          err_d   = 2'b01;
        end
      end
      StExec: begin
        case (op_q)
          OpRtype, OpAddi: state_d = StWb;
          OpLw, OpSw: begin
            state_d = StMem;
            wait_d  = '0;
          end
          OpBeq, OpJ: retire = 1'b1;
          default: begin
            state_d = StHalt;
            err_d   = 2'b01;
          end
        endcase
      end
      StMem: begin
        if (mem_ready) begin
          if (op_q == OpLw) state_d = StWb;
          else              retire  = 1'b1;
        end else if (wait_q == WaitLast) begin
          state_d = StHalt;
          err_d   = 2'b10;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWb:    retire  = 1'b1;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
    if (retire) begin
      state_d   = run ? StFetch : StIdle;
      retired_d = retired_q + 32'd1;
    end
  end

  always_comb begin
    pc_we   = 1'b0;
    pc_src  = 2'b00;
    ir_we   = 1'b0;
    reg_we  = 1'b0;
    reg_dst = 1'b0;
    alu_src = 1'b0;
    alu_op  = 3'b000;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    wb_sel  = 1'b0;
    halted  = 1'b0;
    case (state_q)
      StFetch: ir_we = 1'b1;
      StExec: begin
        case (op_q)
          OpRtype: alu_op = 3'b010;
          OpAddi, OpLw, OpSw: alu_src = 1'b1;
          OpBeq: begin
            alu_op = 3'b001;
            pc_we  = 1'b1;
            pc_src = zero ? 2'b01 : 2'b00;
          end
          OpJ: begin
            pc_we  = 1'b1;
            pc_src = 2'b10;
          end
          default: ;
        endcase
      end
      StMem: begin
        // Address path held stable for the whole access.
        alu_src = 1'b1;
        mem_re  = (op_q == OpLw);
        mem_we  = (op_q == OpSw);
        pc_we   = (op_q == OpSw) && mem_ready;
      end
      StWb: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        reg_dst = (op_q == OpRtype);
        wb_sel  = (op_q != OpLw);
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

  assign state   = state_q;
  assign err     = err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic        CLK = 1'b0;
  logic        RST;
  logic        run;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        ir_we;
  logic        reg_we;
  logic        reg_dst;
  logic        alu_src;
  logic [2:0]  alu_op;
  logic        mem_re;
  logic        mem_we;
  logic        wb_sel;
  logic [2:0]  state;
  logic        halted;
  logic [1:0]  err;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  multicycle_controller #(.MEM_TIMEOUT(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .run       (run),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .ir_we     (ir_we),
    .reg_we    (reg_we),
    .reg_dst   (reg_dst),
    .alu_src   (alu_src),
    .alu_op    (alu_op),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .wb_sel    (wb_sel),
    .state     (state),
    .halted    (halted),
    .err       (err),
    .retired   (retired)
  );

  always #5 CLK = ~CLK;

  logic [13:0] outs;
  assign outs = {pc_we, pc_src, ir_we, reg_we, reg_dst, alu_src, alu_op,
                 mem_re, mem_we, wb_sel, halted};

  // Pack expected strobes in the same order as outs.
  function automatic logic [13:0] pk(input logic pw, input logic [1:0] ps, input logic iw,
                                     input logic rw, input logic rd, input logic as,
                                     input logic [2:0] ao, input logic mr, input logic mw,
                                     input logic ws, input logic h);
    return {pw, ps, iw, rw, rd, as, ao, mr, mw, ws, h};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; run = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs", 32'(outs), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_retired", retired, 32'd0);
    RST = 1'b0;
    step();
    check("post_rst_outs", 32'(outs), 32'd0);
    check("post_rst_state", 32'(state), 32'd0);

    // R-type add
    op = 6'b000000; funct = 6'b100000; run = 1'b1;
    step();
    check("r_fetch_state", 32'(state), 32'd1);
    check("r_fetch_outs", 32'(outs), 32'(pk(0, 2'b00, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0)));
    run = 1'b0;
    step();
    check("r_decode_state", 32'(state), 32'd2);
    check("r_decode_outs", 32'(outs), 32'd0);
    step();
    check("r_exec_state", 32'(state), 32'd3);
    check("r_exec_outs", 32'(outs), 32'(pk(0, 2'b00, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0)));
    step();
    check("r_wb_state", 32'(state), 32'd5);
    check("r_wb_outs", 32'(outs), 32'(pk(1, 2'b00, 0, 1, 1, 0, 3'b000, 0, 0, 1, 0)));
    check("r_wb_retired", retired, 32'd0);
    step();
    check("r_idle_state", 32'(state), 32'd0);
    check("r_retired", retired, 32'd1);

    // lw with mem_ready on the third MEM cycle: F D E M M M WB = 7 cycles
    op = 6'b100011; run = 1'b1;
    step();
    check("lw_fetch_state", 32'(state), 32'd1);
    run = 1'b0;
    step();
    step();
    check("lw_exec_outs", 32'(outs), 32'(pk(0, 2'b00, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0)));
    for (int i = 0; i < 3; i++) begin
      step();
      check("lw_mem_state", 32'(state), 32'd4);
      check("lw_mem_outs", 32'(outs), 32'(pk(0, 2'b00, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0)));
    end
    mem_ready = 1'b1;
    #1;
    check("lw_mem_ready_outs", 32'(outs), 32'(pk(0, 2'b00, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0)));
    step();
    mem_ready = 1'b0;
    check("lw_wb_state", 32'(state), 32'd5);
    check("lw_wb_outs", 32'(outs), 32'(pk(1, 2'b00, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0)));
    step();
    check("lw_idle_state", 32'(state), 32'd0);
    check("lw_retired", retired, 32'd2);

    // beq taken, then beq not taken
    op = 6'b000100; zero = 1'b1; run = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    check("beq1_exec_outs", 32'(outs), 32'(pk(1, 2'b01, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0)));
    zero = 1'b0;
    #1;
    check("beq1_live_zero", 32'(pc_src), 32'd0);
    zero = 1'b1;
    step();
    check("beq1_idle", 32'(state), 32'd0);
    check("beq1_retired", retired, 32'd3);
    zero = 1'b0; run = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    check("beq0_exec_outs", 32'(outs), 32'(pk(1, 2'b00, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0)));
    step();
    check("beq0_idle", 32'(state), 32'd0);
    check("beq0_retired", retired, 32'd4);

    // Counter wrap with j; run dropped during EXEC
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    step();
    check("force_retired", retired, 32'hFFFF_FFFF);
    op = 6'b000010; run = 1'b1;
    step();
    step();
    step();
    check("j_exec_state", 32'(state), 32'd3);
    check("j_exec_outs", 32'(outs), 32'(pk(1, 2'b10, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0)));
    run = 1'b0;
    step();
    check("j_idle_state", 32'(state), 32'd0);
    check("j_wrap", retired, 32'd0);

    // Back-to-back j with run held: retire goes straight to FETCH
    run = 1'b1;
    step();
    step();
    step();
    step();
    check("j2_refetch_state", 32'(state), 32'd1);
    check("j2_retired", retired, 32'd1);
    run = 1'b0;
    step();
    step();
    step();
    check("j3_idle_state", 32'(state), 32'd0);
    check("j3_retired", retired, 32'd2);

    // sw timeout: 16 MEM cycles without mem_ready, then HALT
    op = 6'b101011; run = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    for (int i = 0; i < 16; i++) begin
      step();
      check("sw_to_mem_state", 32'(state), 32'd4);
      check("sw_to_mem_outs", 32'(outs), 32'(pk(0, 2'b00, 0, 0, 0, 1, 3'b000, 0, 1, 0, 0)));
    end
    step();
    check("sw_to_halt_state", 32'(state), 32'd6);
    check("sw_to_err", 32'(err), 32'd2);
    check("sw_to_retired", retired, 32'd2);
    check("sw_to_halt_outs", 32'(outs), 32'(pk(0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1)));
    mem_ready = 1'b1; run = 1'b1;
    step();
    step();
    check("halt_sticky_state", 32'(state), 32'd6);
    check("halt_sticky_err", 32'(err), 32'd2);
    mem_ready = 1'b0; run = 1'b0;
    RST = 1'b1;
    #1;
    check("rst1_state", 32'(state), 32'd0);
    check("rst1_err", 32'(err), 32'd0);
    check("rst1_retired", retired, 32'd0);
    step();
    RST = 1'b0;

    // sw with mem_ready arriving on exactly the 16th MEM cycle completes
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    for (int i = 0; i < 15; i++) step();
    step();
    check("sw16_mem_state", 32'(state), 32'd4);
    mem_ready = 1'b1;
    #1;
    check("sw16_mem_outs", 32'(outs), 32'(pk(1, 2'b00, 0, 0, 0, 1, 3'b000, 0, 1, 0, 0)));
    step();
    mem_ready = 1'b0;
    check("sw16_idle_state", 32'(state), 32'd0);
    check("sw16_err", 32'(err), 32'd0);
    check("sw16_retired", retired, 32'd1);

    // Illegal opcode
    op = 6'b111111; run = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    check("ill_state", 32'(state), 32'd6);
    check("ill_err", 32'(err), 32'd1);
    check("ill_outs", 32'(outs), 32'(pk(0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1)));
    check("ill_retired", retired, 32'd1);
    RST = 1'b1;
    #1;
    check("rst2_state", 32'(state), 32'd0);
    check("rst2_err", 32'(err), 32'd0);
    check("rst2_retired", retired, 32'd0);
    step();
    RST = 1'b0;

    // Reset in the middle of a lw access drops mem_re at once, no retire
    op = 6'b100011; run = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    step();
    check("lwrst_mem_re", 32'(mem_re), 32'd1);
    RST = 1'b1;
    #1;
    check("lwrst_outs", 32'(outs), 32'd0);
    check("lwrst_state", 32'(state), 32'd0);
    check("lwrst_retired", retired, 32'd0);
    step();
    RST = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencing FSM for the MIPS-style datapath. It splits each instruction into FETCH / DECODE / EXEC / MEM / WB steps and drives every datapath write enable, mux select and ALU-op code. It waits on the data-memory ready handshake and counts retired instructions. It replaces the combinational opcode controller and sits between the instruction register and the PC, register bank, ALU control and data memory.

## Interface
- MEM_TIMEOUT, 16, maximum cycles spent in MEM waiting for mem_ready (≥1)
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- run  in  1  1 = execute instructions; 0 = stop at next instruction boundary
- op  in  6  instruction[31:26] from instruction register
- funct  in  6  instruction[5:0]
- zero  in  1  ALU Zero_Flag
- mem_ready  in  1  data memory has completed the current read/write
- pc_we  out  1  PC load enable
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target
- ir_we  out  1  instruction register load
- reg_we  out  1  register bank write enable
- reg_dst  out  1  1 = rd (instr[15:11]), 0 = rt (instr[20:16])
- alu_src  out  1  0 = register B, 1 = sign-extended immediate
- alu_op  out  3  000 add, 001 sub, 010 decode funct (ALU control encoding)
- mem_re, mem_we  out  1  data memory read / write strobes
- wb_sel  out  1  1 = ALU result, 0 = memory data (write-back mux)
- state  out  3  current state code
- halted  out  1  1 while in HALT
- err  out  2  00 none, 01 illegal opcode, 10 memory timeout (sticky)
- retired  out  32  retired-instruction counter

## Operation
- Supported opcodes:
  - 000000 R-type (funct passed through via alu_op 010)
  - 001000 addi
  - 100011 lw
  - 101011 sw
  - 000100 beq
  - 000010 j
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- op and funct are latched internally in DECODE. All later states use the latched copy.
- Outputs are Moore, decoded from state and latched op. Exceptions: pc_src in EXEC for beq uses the live zero input, and the mem strobes depend on mem_ready only for leaving MEM. Any output not listed for a state is 0.
- IDLE: no outputs. run=1 → FETCH.
- FETCH: ir_we=1 → DECODE.
- DECODE: illegal op → HALT with err=01; otherwise → EXEC.
- EXEC:
  - R-type: alu_op=010, alu_src=0 → WB.
  - addi: alu_op=000, alu_src=1 → WB.
  - lw/sw: alu_op=000, alu_src=1 → MEM.
  - beq: alu_op=001, alu_src=0, pc_we=1, pc_src=01 if zero else 00; retire.
  - j: pc_we=1, pc_src=10; retire.
- MEM:
  - alu_op=000 and alu_src=1 are held so the address stays stable.
  - lw holds mem_re=1; sw holds mem_we=1.
  - On mem_ready=1, lw → WB.
  - On mem_ready=1, sw asserts pc_we=1, pc_src=00 and retires in that same cycle.
- WB: reg_we=1, pc_we=1, pc_src=00; retire.
  - R-type: reg_dst=1, wb_sel=1.
  - addi: reg_dst=0, wb_sel=1.
  - lw: reg_dst=0, wb_sel=0.
- Retire: retired increments by 1, wrapping 0xFFFFFFFF→0. Next state is FETCH if run=1, else IDLE.
- HALT: all strobes 0, halted=1. Exit only via RST.
- err is set only on entry to HALT and is cleared only by RST.

## Timing
- Reset (async) puts the block in IDLE. All outputs are 0, retired=0, err=00, and the wait counter is 0. No strobe is asserted in the first cycle after RST deasserts.
- Cycles per instruction, FETCH through retire inclusive, with W = cycles spent in MEM (1..MEM_TIMEOUT):
  - beq, j: 3
  - R-type, addi: 4
  - sw: 3+W
  - lw: 4+W
- mem_ready is sampled at each rising edge while in MEM, so MEM lasts at least 1 cycle. mem_ready already high on MEM entry gives W=1. mem_ready outside MEM is ignored.
- Wait counter:
  - Reset to 0 on MEM entry; increments each MEM cycle without mem_ready.
  - If the MEM_TIMEOUT-th MEM cycle has mem_ready=0, the next state is HALT with err=10 and no retire.
  - mem_ready=1 on exactly that cycle completes normally.
- run=0 mid-instruction: the current instruction completes and retires, then the block goes to IDLE. run is checked only at retire and in IDLE.
- RST mid-instruction: immediate IDLE. A partially executed instruction does not retire, and a held strobe drops asynchronously.
- pc_we is asserted exactly once per retired instruction. ir_we is asserted exactly once per FETCH.

## Test plan
- R-type add (op=000000, funct=100000), run=1 → states 1,2,3,5; WB has reg_we=1, reg_dst=1, wb_sel=1, pc_we=1, pc_src=00; retired=1 after 4 cycles.
- lw with mem_ready delayed 3 cycles → MEM lasts 3 cycles with mem_re=1 throughout, then WB with wb_sel=0, reg_dst=0; instruction takes 7 cycles.
- beq with zero=1 → EXEC asserts pc_we=1, pc_src=01. Repeat with zero=0 → pc_src=00. Each takes 3 cycles.
- sw with mem_ready never asserted, MEM_TIMEOUT=16 → 16 MEM cycles, then HALT, err=10, retired unchanged, halted=1 until RST.
- op=111111 → HALT after DECODE with err=01. Then assert RST → IDLE, err=00, retired=0.
- Preload retired=0xFFFFFFFF (force) and run j → retired=0. Drop run during EXEC of j → the j retires, then the block enters IDLE.
